// File: rtl/product_fifo.sv
`default_nettype none
// ============================================================================
// Module      : product_fifo
// Description : Valid/ready FIFO buffering {x, y} product records. Optional
//               occupancy port O_level enabled by PRODUCT_FIFO_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module product_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I_x,
    input  logic [WIDTH-1:0] I_y,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O_x,
    output logic [WIDTH-1:0] O_y,
    output logic             O_valid,
    input  logic             O_ready
`ifdef PRODUCT_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] O_level
`endif
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]    r_wp;
    logic [c_AW-1:0]    r_rp;
    logic [c_CW-1:0]    r_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head;

    assign w_full  = (r_cnt == c_DEPTH);
    assign w_empty = (r_cnt == '0);
    assign w_push  = I_valid && !w_full;
    assign w_pop   = O_ready && !w_empty;

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

    // Storage is never reset; stale contents are hidden while empty.
    always_ff @(posedge CLK) begin
        if (!RESET && w_push) begin
            r_mem[r_wp] <= {I_x, I_y};
        end
    end

    assign w_head  = r_mem[r_rp];
    assign I_ready = !w_full;
    assign O_valid = !w_empty;
    assign O_x     = w_empty ? '0 : w_head[2*WIDTH-1:WIDTH];
    assign O_y     = w_empty ? '0 : w_head[WIDTH-1:0];

`ifdef PRODUCT_FIFO_LEVEL_EN
    assign O_level = r_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/product_fifo.md
# product_fifo

Synchronous FIFO that buffers product records {x, y} produced by the upstream combinational stage (the `_comb` instance) before they reach downstream consumers. It decouples the producer from back-pressure with a valid/ready handshake on both sides. It has no combinational path from `O_ready` to `I_ready`.

## Interface

Clock and reset: one clock `CLK`; reset `RESET` is synchronous and active-high.

Parameters:
- `WIDTH`, default 1: bit width of each field, `x` and `y`.
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.

Ports:
- `CLK`  input  1  clock; all state updates on the rising edge.
- `RESET`  input  1  synchronous, active-high reset.
- `I_x`  input  WIDTH  field `x` of the incoming record.
- `I_y`  input  WIDTH  field `y` of the incoming record.
- `I_valid`  input  1  upstream presents a record.
- `I_ready`  output  1  FIFO can accept a record this cycle.
- `O_x`  output  WIDTH  field `x` of the head record.
- `O_y`  output  WIDTH  field `y` of the head record.
- `O_valid`  output  1  head record is valid.
- `O_ready`  input  1  downstream accepts the head record.
- `O_level`  output  clog2(DEPTH+1)  current occupancy. Present only with `PRODUCT_FIFO_LEVEL_EN`.

## Operation

- Storage: DEPTH entries of {x, y}, 2·WIDTH bits each, kept in a register array.
- State:
  - write pointer `wp` and read pointer `rp`, each clog2(DEPTH) bits;
  - occupancy `cnt`, range 0..DEPTH.
- Flags:
  - `full` = (`cnt` == DEPTH);
  - `empty` = (`cnt` == 0).
- Ready/valid:
  - `I_ready` = !`full`. Depends only on registered state.
  - `O_valid` = !`empty`. Depends only on registered state.
- Push: when `I_valid` && `I_ready`, write {`I_x`, `I_y`} to entry `wp`, then `wp` ← `wp`+1.
- Pop: when `O_valid` && `O_ready`, `rp` ← `rp`+1.
- Pointer wrap: both pointers wrap modulo DEPTH by natural overflow; no extra wrap logic.
- Occupancy update:
  - push only: `cnt`+1;
  - pop only: `cnt`−1;
  - push and pop in the same cycle: `cnt` unchanged, and both pointers advance.
- Head output: `O_x`/`O_y` = entry `rp` when !`empty`. When `empty`, both are forced to 0.
- Full: `I_ready`=0, so no push can occur. A pop in that cycle still frees one slot, but `I_ready` rises only on the next cycle.
- Empty: `O_valid`=0, so no pop can occur. There is no fall-through: a record written while empty becomes visible the following cycle.
- Protocol:
  - Upstream must hold `I_x`/`I_y` stable while `I_valid` && !`I_ready`.
  - The FIFO holds `O_x`/`O_y` stable while `O_valid` && !`O_ready`.
- Ignored inputs:
  - `I_valid` while `full` is ignored; no overwrite and no error.
  - `O_ready` while `empty` is ignored.

## Timing

- Reset values (after any `RESET` edge):
  - `wp`=0, `rp`=0, `cnt`=0;
  - `I_ready`=1, `O_valid`=0, `O_x`=0, `O_y`=0, `O_level`=0.
  - Storage contents are not reset; they are masked by `empty`.
- Reset mid-operation: all buffered records are discarded on that edge, and `RESET` has priority over a simultaneous push/pop. One cycle after `RESET` deasserts, the FIFO accepts pushes.
- Latency: a record pushed at edge k appears on `O_*` with `O_valid`=1 after edge k, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained while 0 < `cnt` < DEPTH.
- Output timing: all outputs are functions of registered state only. `O_x`/`O_y` pass through one read mux from the register array.

## Configuration

- Macro `PRODUCT_FIFO_LEVEL_EN` defined:
  - port `O_level` exists and equals `cnt`;
  - it updates in the same cycle as the flags.
- Macro undefined:
  - the `O_level` port is absent;
  - all other behaviour is identical.

## Test plan

- Reset then idle:
  - hold `RESET`=1 for 2 cycles, then release.
  - Required: `I_ready`=1, `O_valid`=0, `O_x`=`O_y`=0, `O_level`=0.
- Fill to full (DEPTH=4, WIDTH=1, `O_ready`=0):
  - push {1,0},{0,1},{1,1},{0,0}.
  - Required: `I_ready`=0 after the 4th edge, `O_level`=4, and a 5th push of {1,1} is ignored.
- Drain in order:
  - from full, set `O_ready`=1 for 4 cycles.
  - Required: `O_x`/`O_y` sequence is 1/0, 0/1, 1/1, 0/0; then `O_valid`=0 and `O_x`=`O_y`=0.
- Simultaneous push/pop:
  - with `cnt`=2, hold `I_valid`=`O_ready`=1 for 8 cycles.
  - Required: `cnt` stays 2, output order equals input order, and the pointers wrap twice without loss.
- Pop-while-full:
  - at `cnt`=4 assert `O_ready`=1 and `I_valid`=1.
  - Required: no push that cycle, `I_ready`=1 the next cycle, and `cnt`=3.
- Reset mid-stream:
  - with `cnt`=3, pulse `RESET` together with `I_valid`=`O_ready`=1.
  - Required: the next cycle shows `cnt`=0, `O_valid`=0, `I_ready`=1, and no record emitted from before the reset.
